sysid_probe: RTL and testbench
==============================

# sysid_probe

Avalon-MM master that reads the two-word system ID slave (word 0 = system ID, word 1 = build timestamp) after reset or on request. It compares both words against expected values and reports pass/fail/timeout status. It sits beside the host bridge in the DE4 DDR2 system, so firmware and the status LEDs can confirm that the loaded bitstream matches the software build before DDR2 traffic starts.

## Interface
Parameters:
- EXP_ID, 32'h3021C96C, expected system ID word.
- EXP_TS, 32'h4EBD3BEC, expected timestamp word.
- TIMEOUT_CYC, 1024, max cycles per read transaction before abort; must be ≥ 2.
- AUTO_START, 1, when 1, probe starts automatically on the first cycle after reset deasserts.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a probe when idle.
- avm_address  out  1  word address to sysid slave (0 = ID, 1 = timestamp).
- avm_read  out  1  read strobe.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  32  read data.
- avm_readdatavalid  in  1  read data qualifier.
- busy  out  1  probe in progress.
- done  out  1  one-cycle pulse at probe completion.
- id_ok  out  1  captured ID == EXP_ID (sticky until next probe).
- ts_ok  out  1  captured timestamp == EXP_TS (sticky).
- timed_out  out  1  last probe aborted on timeout (sticky).
- id_value  out  32  captured ID word.
- ts_value  out  32  captured timestamp word.

## Operation
- FSM states: IDLE, REQ_ID, WAIT_ID, REQ_TS, WAIT_TS, FINISH.
- IDLE: if start=1, or if this is the first post-reset cycle and AUTO_START=1 → REQ_ID. Starting a probe clears id_ok, ts_ok, and timed_out.
- REQ_ID: assert avm_read=1 and avm_address=0. Hold both until avm_waitrequest=0, then → WAIT_ID.
- WAIT_ID: on avm_readdatavalid=1, capture avm_readdata into id_value, set id_ok = (data==EXP_ID), then → REQ_TS.
- REQ_TS and WAIT_TS: the same sequence with avm_address=1, capturing into ts_value and ts_ok, then → FINISH.
- FINISH: pulse done=1 for one cycle, then → IDLE.
- If readdatavalid arrives in the same cycle the request is accepted (zero-latency slave), capture immediately and skip the WAIT state.
- start while busy is ignored (not queued).
- readdatavalid seen in IDLE or REQ_* without an outstanding read is ignored.
- Comparison is a full 32-bit equality with no masking.

## Timing
- Reset values: avm_read=0, avm_address=0, busy=0, done=0, id_ok=0, ts_ok=0, timed_out=0, id_value=0, ts_value=0, FSM=IDLE.
- All outputs are registered.
- busy rises the cycle after the start pulse and falls in the same cycle that done pulses.
- Minimum probe with a zero-wait, zero-latency slave: start at cycle 0, avm_read at cycles 1–2, done at cycle 3.
- avm_address and avm_read are stable while avm_waitrequest=1.
- Reset asserted mid-probe returns all outputs to their reset values on the next edge. An outstanding read is abandoned, and its late readdatavalid is ignored.

## Configuration
- SYSID_PROBE_TIMEOUT_EN defined: a per-transaction counter (width $clog2(TIMEOUT_CYC+1)) loads at each REQ_* entry and counts every cycle in REQ_*/WAIT_*.
  - When the count reaches TIMEOUT_CYC: deassert avm_read, set timed_out=1, leave the uncaptured *_ok at 0, → FINISH (done pulses).
- Not defined: no counter. The FSM waits indefinitely, and timed_out is tied to 0.

## Structure
- Shared package sysid_pkg:
  - state enum;
  - SYSID_ADDR_ID=1'b0 and SYSID_ADDR_TS=1'b1;
  - default EXP_ID/EXP_TS constants, also used by the sysid slave generator.
- No sub-module; the timeout counter is inline. The bench instantiates the existing sysid slave as the DUT's partner, wrapped with a waitrequest/latency injector.

## Test plan
- AUTO_START=1, zero-wait slave returning 0x3021C96C / 0x4EBD3BEC → done at cycle 3 after reset release; id_ok=1, ts_ok=1, timed_out=0.
- Slave returns 0x3021C96C / 0x00000000 → id_ok=1, ts_ok=0, ts_value=0; done pulses once.
- waitrequest held for 5 cycles per read, readdatavalid 3 cycles after acceptance → address/read stable throughout; correct capture; done after 20 cycles.
- SYSID_PROBE_TIMEOUT_EN with TIMEOUT_CYC=16, slave never asserts readdatavalid on word 1 → avm_read drops; timed_out=1, id_ok=1, ts_ok=0; done pulses.
- start pulsed while busy, and reset asserted during WAIT_TS → start ignored; all outputs at reset values the next cycle; a stray readdatavalid afterwards does not change id_value/ts_value.

Source files
------------

// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID probe and the sysid slave generator:
// probe FSM states, slave word addresses and the default expected words.
package sysid_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ_ID,
      S_WAIT_ID,
      S_REQ_TS,
      S_WAIT_TS,
      S_FINISH
   } state_t;

   localparam logic        SYSID_ADDR_ID = 1'b0;
   localparam logic        SYSID_ADDR_TS = 1'b1;

   localparam logic [31:0] SYSID_EXP_ID  = 32'h3021C96C;
   localparam logic [31:0] SYSID_EXP_TS  = 32'h4EBD3BEC;

   // True while a read transaction is in flight (request or data phase).
   function automatic logic inTransaction(input state_t s);
      return (s == S_REQ_ID) || (s == S_WAIT_ID) ||
             (s == S_REQ_TS) || (s == S_WAIT_TS);
   endfunction

endpackage

// File: rtl/sysid_probe.sv
// Avalon-MM master that reads the sysid ID and timestamp words and compares them
// against expected values. Define SYSID_PROBE_TIMEOUT_EN to add a per-read abort timer.
module sysid_probe
   import sysid_pkg::*;
#(
   parameter logic [31:0] EXP_ID      = SYSID_EXP_ID,
   parameter logic [31:0] EXP_TS      = SYSID_EXP_TS,
   parameter int unsigned TIMEOUT_CYC = 1024,
   parameter bit          AUTO_START  = 1'b1
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   input  logic        avm_readdatavalid,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timed_out,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   if (TIMEOUT_CYC < 2) begin : g_badTimeoutCfg
      $error("sysid_probe: TIMEOUT_CYC must be at least 2");
   end

   state_t      r_state;
   logic        r_read;
   logic        r_addr;
   logic        r_busy;
   logic        r_done;
   logic        r_idOk;
   logic        r_tsOk;
   logic        r_firstCycle;
   logic [31:0] r_idValue;
   logic [31:0] r_tsValue;

   logic        w_accept;
   logic        w_startReq;
   logic        w_capture;

   assign w_accept   = r_read && !avm_waitrequest;
   assign w_startReq = start || (r_firstCycle && AUTO_START);

   // Data only counts when a read is outstanding: accepted this cycle or already waiting.
   assign w_capture  = ((r_state == S_REQ_ID  || r_state == S_REQ_TS) && w_accept && avm_readdatavalid) ||
                       ((r_state == S_WAIT_ID || r_state == S_WAIT_TS) && avm_readdatavalid);

`ifdef SYSID_PROBE_TIMEOUT_EN
   localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_timedOut;
   logic             w_expire;

   assign w_expire  = inTransaction(r_state) && (r_cnt == CNT_LAST) && !w_capture;
   assign timed_out = r_timedOut;
`else
   assign timed_out = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_read       <= 1'b0;
         r_addr       <= SYSID_ADDR_ID;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_idOk       <= 1'b0;
         r_tsOk       <= 1'b0;
         r_idValue    <= '0;
         r_tsValue    <= '0;
         r_firstCycle <= 1'b1;
`ifdef SYSID_PROBE_TIMEOUT_EN
         r_cnt        <= '0;
         r_timedOut   <= 1'b0;
`endif
      end else begin
         r_firstCycle <= 1'b0;
         r_done       <= 1'b0;
`ifdef SYSID_PROBE_TIMEOUT_EN
         if (inTransaction(r_state)) begin
            r_cnt <= r_cnt + 1'b1;
         end
`endif
         unique case (r_state)
            S_IDLE: begin
               if (w_startReq) begin
                  r_state <= S_REQ_ID;
                  r_read  <= 1'b1;
                  r_addr  <= SYSID_ADDR_ID;
                  r_busy  <= 1'b1;
                  r_idOk  <= 1'b0;
                  r_tsOk  <= 1'b0;
`ifdef SYSID_PROBE_TIMEOUT_EN
                  r_cnt      <= '0;
                  r_timedOut <= 1'b0;
`endif
               end
            end
            S_REQ_ID, S_WAIT_ID: begin
               if (w_capture) begin
                  r_idValue <= avm_readdata;
                  r_idOk    <= (avm_readdata == EXP_ID);
                  r_state   <= S_REQ_TS;
                  r_read    <= 1'b1;
                  r_addr    <= SYSID_ADDR_TS;
`ifdef SYSID_PROBE_TIMEOUT_EN
                  r_cnt     <= '0;
`endif
               end else if (w_accept) begin
                  r_read  <= 1'b0;
                  r_state <= S_WAIT_ID;
               end
            end
            S_REQ_TS, S_WAIT_TS: begin
               if (w_capture) begin
                  r_tsValue <= avm_readdata;
                  r_tsOk    <= (avm_readdata == EXP_TS);
                  r_state   <= S_FINISH;
                  r_read    <= 1'b0;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
               end else if (w_accept) begin
                  r_read  <= 1'b0;
                  r_state <= S_WAIT_TS;
               end
            end
            S_FINISH: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
`ifdef SYSID_PROBE_TIMEOUT_EN
         // Abort overrides whatever the case above decided for this cycle.
         if (w_expire) begin
            r_state    <= S_FINISH;
            r_read     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_timedOut <= 1'b1;
         end
`endif
      end
   end

   assign avm_address = r_addr;
   assign avm_read    = r_read;
   assign busy        = r_busy;
   assign done        = r_done;
   assign id_ok       = r_idOk;
   assign ts_ok       = r_tsOk;
   assign id_value    = r_idValue;
   assign ts_value    = r_tsValue;

endmodule

// File: tb/tb_sysid_probe.sv
// Bench for sysid_probe: behavioural sysid slave with wait/latency injection and a
// cycle-count model of each probe derived from the read protocol rules.
module tb_sysid_probe;

   localparam logic [31:0] EXP_ID = 32'h3021C96C;
   localparam logic [31:0] EXP_TS = 32'h4EBD3BEC;
   localparam int          TO_CYC = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        avm_address;
   logic        avm_read;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;
   logic        avm_readdatavalid;
   logic        busy;
   logic        done;
   logic        id_ok;
   logic        ts_ok;
   logic        timed_out;
   logic [31:0] id_value;
   logic [31:0] ts_value;

   int total = 0;
   int bad = 0;

   int          cfgWait [2];
   int          cfgLat  [2];
   logic [31:0] cfgData [2];
   bit          cfgDrop1 = 1'b0;
   bit          injValid = 1'b0;
   logic [31:0] injData  = 32'h0;
   logic [31:0] lastTs   = 32'h0;

   int   waitCnt = 0;
   int   pendCnt = 0;
   logic pending = 1'b0;
   logic pendAddr = 1'b0;
   logic zeroValid;
   logic lateValid;

   always #5 clk = ~clk;

   sysid_probe #(
      .EXP_ID      (EXP_ID),
      .EXP_TS      (EXP_TS),
      .TIMEOUT_CYC (TO_CYC),
      .AUTO_START  (1'b1)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .start             (start),
      .avm_address       (avm_address),
      .avm_read          (avm_read),
      .avm_waitrequest   (avm_waitrequest),
      .avm_readdata      (avm_readdata),
      .avm_readdatavalid (avm_readdatavalid),
      .busy              (busy),
      .done              (done),
      .id_ok             (id_ok),
      .ts_ok             (ts_ok),
      .timed_out         (timed_out),
      .id_value          (id_value),
      .ts_value          (ts_value)
   );

   // Two-word sysid slave wrapped by a waitrequest/latency injector.
   assign avm_waitrequest   = avm_read && (waitCnt < cfgWait[avm_address]);
   assign zeroValid         = avm_read && !avm_waitrequest && (cfgLat[avm_address] == 0) &&
                              !(cfgDrop1 && avm_address);
   assign lateValid         = pending && (pendCnt == 1) && !(cfgDrop1 && pendAddr);
   assign avm_readdatavalid = zeroValid || lateValid || injValid;
   assign avm_readdata      = injValid  ? injData :
                              zeroValid ? cfgData[avm_address] :
                              lateValid ? cfgData[pendAddr] : 32'hDEADBEEF;

   always @(posedge clk) begin
      if (reset) begin
         waitCnt  <= 0;
         pendCnt  <= 0;
         pending  <= 1'b0;
         pendAddr <= 1'b0;
      end else begin
         if (pending) begin
            pendCnt <= pendCnt - 1;
            if (pendCnt == 1) pending <= 1'b0;
         end
         if (avm_read && avm_waitrequest) begin
            waitCnt <= waitCnt + 1;
         end else if (avm_read) begin
            waitCnt <= 0;
            if (cfgLat[avm_address] > 0) begin
               pending  <= 1'b1;
               pendCnt  <= cfgLat[avm_address];
               pendAddr <= avm_address;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, ".read"},     avm_read,    0);
      checkOutput({tag, ".addr"},     avm_address, 0);
      checkOutput({tag, ".busy"},     busy,        0);
      checkOutput({tag, ".done"},     done,        0);
      checkOutput({tag, ".idOk"},     id_ok,       0);
      checkOutput({tag, ".tsOk"},     ts_ok,       0);
      checkOutput({tag, ".timedOut"}, timed_out,   0);
      checkOutput({tag, ".idValue"},  id_value,    0);
      checkOutput({tag, ".tsValue"},  ts_value,    0);
   endtask

   // One probe: cycle 0 is the start (or first post-reset) cycle. Each read takes
   // wait+1 request cycles plus latency data cycles; a dropped word takes TO_CYC cycles.
   task automatic applyStimulus(input bit useStart, input int w0, input int l0, input int w1,
                                input int l1, input logic [31:0] d0, input logic [31:0] d1,
                                input bit drop1, input int startAgainAt);
      int   doneAt;
      int   tsStart;
      int   cyc;
      bit   expRead;
      logic expAddr;
      cfgWait[0] = w0;  cfgLat[0] = l0;  cfgData[0] = d0;
      cfgWait[1] = w1;  cfgLat[1] = l1;  cfgData[1] = d1;
      cfgDrop1   = drop1;
      tsStart = 2 + w0 + l0;
      doneAt  = tsStart + (drop1 ? TO_CYC : (w1 + 1 + l1));
      if (useStart) start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 1;
      while (cyc <= doneAt + 2) begin
         expRead = ((cyc >= 1) && (cyc <= 1 + w0)) || ((cyc >= tsStart) && (cyc <= tsStart + w1));
         expAddr = (cyc >= tsStart);
         checkOutput("read", avm_read, expRead);
         if (expRead) checkOutput("addr", avm_address, expAddr);
         checkOutput("busy", busy, (cyc < doneAt));
         checkOutput("done", done, (cyc == doneAt));
         if (cyc == 1) begin
            checkOutput("idOkCleared", id_ok, 0);
            checkOutput("tsOkCleared", ts_ok, 0);
            checkOutput("timedOutCleared", timed_out, 0);
         end
         if (cyc == doneAt) begin
            checkOutput("idValue",  id_value,  d0);
            checkOutput("idOk",     id_ok,     (d0 == EXP_ID));
            checkOutput("tsValue",  ts_value,  drop1 ? lastTs : d1);
            checkOutput("tsOk",     ts_ok,     !drop1 && (d1 == EXP_TS));
            checkOutput("timedOut", timed_out, drop1);
         end
         start = ((cyc == startAgainAt) && (cyc < doneAt));
         tick();
         cyc++;
      end
      start = 1'b0;
      if (!drop1) lastTs = d1;
   endtask

   function automatic logic [31:0] pickWord(input logic [31:0] good);
      logic [31:0] flip;
      case ($urandom_range(0, 2))
         0:       pickWord = good;
         1:       begin flip = 32'h1 << $urandom_range(0, 31); pickWord = good ^ flip; end
         default: pickWord = $urandom;
      endcase
   endfunction

   initial begin
      cfgWait[0] = 0; cfgWait[1] = 0;
      cfgLat[0]  = 0; cfgLat[1]  = 0;
      cfgData[0] = EXP_ID; cfgData[1] = EXP_TS;

      // Reset values, then auto-started probe on a zero-wait slave (done at cycle 3).
      reset = 1'b1;
      repeat (3) tick();
      checkReset("reset");
      reset = 1'b0;
      applyStimulus(1'b0, 0, 0, 0, 0, EXP_ID, EXP_TS, 1'b0, -1);

      // Timestamp mismatch, explicit start.
      applyStimulus(1'b1, 0, 0, 0, 0, EXP_ID, 32'h0000_0000, 1'b0, -1);

      // Waitrequest 5 cycles, data 3 cycles after acceptance; start pulsed mid-probe.
      applyStimulus(1'b1, 5, 3, 5, 3, EXP_ID, EXP_TS, 1'b0, 4);

`ifdef SYSID_PROBE_TIMEOUT_EN
      // Timestamp read never returns data.
      applyStimulus(1'b1, 0, 1, 2, 1, EXP_ID, EXP_TS, 1'b1, -1);
`endif

      // Randomized slave timing and data.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, $urandom_range(0, 4), $urandom_range(0, 3),
                       $urandom_range(0, 4), $urandom_range(0, 3),
                       pickWord(EXP_ID), pickWord(EXP_TS), 1'b0, $urandom_range(2, 6));
      end

      // Reset in WAIT_TS (cycles 6..9 with this timing), then stray readdatavalid.
      cfgWait[0] = 1; cfgLat[0] = 1; cfgData[0] = EXP_ID;
      cfgWait[1] = 1; cfgLat[1] = 4; cfgData[1] = EXP_TS;
      cfgDrop1 = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (6) tick();
      checkOutput("midBusy", busy, 1);
      reset = 1'b1;
      tick();
      checkReset("midReset");
      injData = 32'hA5A5_5A5A;
      injValid = 1'b1;
      cfgWait[0] = 6; cfgLat[0] = 0; cfgWait[1] = 0; cfgLat[1] = 0;
      tick();
      checkOutput("strayInReset.id", id_value, 0);
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         checkOutput("stray.id", id_value, 0);
         checkOutput("stray.ts", ts_value, 0);
      end
      injValid = 1'b0;
      for (int k = 0; k < 40 && !done; k++) tick();
      checkOutput("postReset.done",    done,     1);
      checkOutput("postReset.idValue", id_value, EXP_ID);
      checkOutput("postReset.tsValue", ts_value, EXP_TS);
      checkOutput("postReset.idOk",    id_ok,    1);
      checkOutput("postReset.tsOk",    ts_ok,    1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
